// File: rtl/op_issue_queue_pkg.sv
// Shared types for the operation issue queue: FIFO request payload and scoreboard entries.
package op_issue_queue_pkg;

  localparam int unsigned REQ_ADDR_W = 8;
  localparam int unsigned REQ_DATA_W = 8;
  localparam int unsigned OP_ID_W    = 8;

  localparam logic [OP_ID_W-1:0] OP_ID_NONE = '0;

  typedef struct packed {
    logic                  wr_rd_op;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wr_data;
  } op_req_t;

  typedef struct packed {
    logic               valid;
    logic [OP_ID_W-1:0] id;
    logic               wr_rd_op;
  } sb_entry_t;

endpackage

// File: rtl/op_issue_queue_fifo.sv
// Synchronous request FIFO of op_req_t; head is visible combinationally on pop_data.
module op_req_fifo
  import op_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  op_req_t push_data,
  input  logic    pop,
  output op_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  op_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/op_issue_queue.sv
// Buffers host requests, issues them to the address decoder with unique non-zero IDs,
// and turns decoder returns into one completion pulse per outstanding operation.
module op_issue_queue
  import op_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned ADDR_W  = REQ_ADDR_W,
  parameter int unsigned DATA_W  = REQ_DATA_W,
  parameter int unsigned ID_W    = OP_ID_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_wr_rd_op,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              enable_in,
  output logic              valid_in,
  output logic              wr_rd_op,
  output logic [ADDR_W-1:0] addr_in,
  output logic [ID_W-1:0]   op_in_id,
  output logic [DATA_W-1:0] wr_data_in,
  input  logic              ready_out,
  input  logic [DATA_W-1:0] rd_data_out,
  input  logic [ID_W-1:0]   done_op_id,
  output logic              cpl_valid,
  output logic [ID_W-1:0]   cpl_id,
  output logic              cpl_wr_rd_op,
  output logic [DATA_W-1:0] cpl_rd_data,
  output logic              err_unexpected
);

  localparam int unsigned SW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          load;
  logic          accept;
  logic          sb_room;
  op_req_t       push_req;
  op_req_t       head_req;
  logic [ID_W-1:0] id_ctr;

  sb_entry_t     sb [MAX_OUT];
  logic [SW:0]   free_cnt;
  logic          alloc_found;
  logic [SW-1:0] alloc_idx;
  logic          match_hit;
  logic [SW-1:0] match_idx;
  logic          match_op;

  assign push_req = '{wr_rd_op: host_wr_rd_op, addr: host_addr, wr_data: host_wr_data};

  op_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_req),
    .pop      (load),
    .pop_data (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign host_ready = !fifo_full;
  assign push       = host_valid && !fifo_full;
  assign accept     = valid_in && ready_out;

  always_comb begin
    free_cnt    = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    match_hit   = 1'b0;
    match_idx   = '0;
    match_op    = 1'b0;
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      if (!sb[i].valid) begin
        free_cnt = free_cnt + 1'b1;
        if (!alloc_found) begin
          alloc_found = 1'b1;
          alloc_idx   = SW'(i);
        end
      end else if (done_op_id != OP_ID_NONE && sb[i].id == done_op_id) begin
        match_hit = 1'b1;
        match_idx = SW'(i);
        match_op  = sb[i].wr_rd_op;
      end
    end
  end

  // Load reserves a slot for the op it issues; a slot freed this edge only counts from the next.
  assign sb_room = accept ? (free_cnt > (SW+1)'(1)) : (free_cnt != '0);
  assign load    = enable_in && !fifo_empty && (!valid_in || accept) && sb_room;

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_in  <= 1'b0;
      valid_in   <= 1'b0;
      wr_rd_op   <= 1'b0;
      addr_in    <= '0;
      wr_data_in <= '0;
      op_in_id   <= '0;
      id_ctr     <= ID_W'(1);
    end else begin
      enable_in <= cfg_enable;
      if (load) begin
        valid_in   <= 1'b1;
        wr_rd_op   <= head_req.wr_rd_op;
        addr_in    <= head_req.addr;
        wr_data_in <= head_req.wr_data;
        op_in_id   <= id_ctr;
        id_ctr     <= (id_ctr == '1) ? ID_W'(1) : id_ctr + 1'b1;
      end else if (accept) begin
        valid_in <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        sb[i] <= '0;
      end
    end else begin
      if (accept) sb[alloc_idx] <= '{valid: 1'b1, id: op_in_id, wr_rd_op: wr_rd_op};
      if (match_hit) sb[match_idx].valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpl_valid      <= 1'b0;
      cpl_id         <= '0;
      cpl_wr_rd_op   <= 1'b0;
      cpl_rd_data    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      cpl_valid      <= match_hit;
      cpl_id         <= match_hit ? done_op_id : '0;
      cpl_wr_rd_op   <= match_hit && match_op;
      cpl_rd_data    <= (match_hit && !match_op) ? rd_data_out : '0;
      err_unexpected <= (done_op_id != OP_ID_NONE) && !match_hit;
    end
  end

endmodule

// File: tb/tb_op_issue_queue.sv
// Directed self-checking bench for op_issue_queue.
module tb_op_issue_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_enable;
  logic       host_valid;
  logic       host_ready;
  logic       host_wr_rd_op;
  logic [7:0] host_addr;
  logic [7:0] host_wr_data;
  logic       enable_in;
  logic       valid_in;
  logic       wr_rd_op;
  logic [7:0] addr_in;
  logic [7:0] op_in_id;
  logic [7:0] wr_data_in;
  logic       ready_out;
  logic [7:0] rd_data_out;
  logic [7:0] done_op_id;
  logic       cpl_valid;
  logic [7:0] cpl_id;
  logic       cpl_wr_rd_op;
  logic [7:0] cpl_rd_data;
  logic       err_unexpected;

  int n_cmp = 0;
  int n_bad = 0;

  op_issue_queue #(
    .DEPTH  (4),
    .MAX_OUT(4),
    .ADDR_W (8),
    .DATA_W (8),
    .ID_W   (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_wr_rd_op (host_wr_rd_op),
    .host_addr     (host_addr),
    .host_wr_data  (host_wr_data),
    .enable_in     (enable_in),
    .valid_in      (valid_in),
    .wr_rd_op      (wr_rd_op),
    .addr_in       (addr_in),
    .op_in_id      (op_in_id),
    .wr_data_in    (wr_data_in),
    .ready_out     (ready_out),
    .rd_data_out   (rd_data_out),
    .done_op_id    (done_op_id),
    .cpl_valid     (cpl_valid),
    .cpl_id        (cpl_id),
    .cpl_wr_rd_op  (cpl_wr_rd_op),
    .cpl_rd_data   (cpl_rd_data),
    .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Push one op, wait for issue, let it be accepted, then complete it.
  task automatic issue_op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] id);
    int unsigned waited;
    host_valid    = 1'b1;
    host_wr_rd_op = wr;
    host_addr     = a;
    host_wr_data  = d;
    tick();
    host_valid = 1'b0;
    waited = 0;
    while (!valid_in && waited < 8) begin
      tick();
      waited++;
    end
    if (!valid_in) check("issue_timeout", 32'd0, 32'd1);
    id = op_in_id;
    tick();
    done_op_id = id;
    tick();
    done_op_id = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] id;
    logic [7:0] done_seq [5];

    reset         = 1'b1;
    cfg_enable    = 1'b1;
    host_valid    = 1'b0;
    host_wr_rd_op = 1'b0;
    host_addr     = 8'h00;
    host_wr_data  = 8'h00;
    ready_out     = 1'b0;
    rd_data_out   = 8'h00;
    done_op_id    = 8'h00;
    tick();
    tick();

    check("rst_host_ready", host_ready, 1);
    check("rst_valid_in", valid_in, 0);
    check("rst_enable_in", enable_in, 0);
    check("rst_op_in_id", op_in_id, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_err", err_unexpected, 0);
    reset = 1'b0;
    tick();
    check("enable_follow", enable_in, 1);

    // Single write
    ready_out     = 1'b1;
    host_valid    = 1'b1;
    host_wr_rd_op = 1'b1;
    host_addr     = 8'h10;
    host_wr_data  = 8'hA5;
    tick();
    host_valid = 1'b0;
    check("sw_no_valid_yet", valid_in, 0);
    tick();
    check("sw_valid_in", valid_in, 1);
    check("sw_op_id", op_in_id, 1);
    check("sw_addr", addr_in, 8'h10);
    check("sw_data", wr_data_in, 8'hA5);
    check("sw_wr", wr_rd_op, 1);
    tick();
    check("sw_accepted", valid_in, 0);
    done_op_id  = 8'h01;
    rd_data_out = 8'h77;
    tick();
    done_op_id = 8'h00;
    check("sw_cpl_valid", cpl_valid, 1);
    check("sw_cpl_id", cpl_id, 1);
    check("sw_cpl_wr", cpl_wr_rd_op, 1);
    check("sw_cpl_data", cpl_rd_data, 0);
    tick();
    check("sw_cpl_pulse", cpl_valid, 0);

    // Backpressure
    do_reset();
    ready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      host_valid    = 1'b1;
      host_wr_rd_op = 1'b1;
      host_addr     = 8'h20 + 8'(k);
      host_wr_data  = 8'h50 + 8'(k);
      tick();
      check("bp_host_ready", host_ready, (k < 4) ? 1 : 0);
    end
    host_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_valid", valid_in, 1);
      check("bp_hold_id", op_in_id, 1);
      check("bp_hold_addr", addr_in, 8'h20);
      check("bp_hold_data", wr_data_in, 8'h50);
      tick();
    end
    ready_out = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_issue_valid", valid_in, 1);
      check("bp_issue_id", op_in_id, 32'(k + 1));
      check("bp_issue_addr", addr_in, 32'(8'h20 + 8'(k)));
      if (k == 1) done_op_id = 8'h01;
      if (k == 2) begin
        done_op_id = 8'h00;
        check("bp_cpl_valid", cpl_valid, 1);
        check("bp_cpl_id", cpl_id, 1);
      end
      tick();
    end
    check("bp_drained", valid_in, 0);
    check("bp_ready_back", host_ready, 1);

    // Scoreboard full
    do_reset();
    ready_out = 1'b1;
    for (int k = 0; k < 5; k++) begin
      host_valid    = 1'b1;
      host_wr_rd_op = 1'b0;
      host_addr     = 8'h30 + 8'(k);
      host_wr_data  = 8'h00;
      tick();
    end
    host_valid = 1'b0;
    check("sf_fourth_id", op_in_id, 4);
    tick();
    check("sf_blocked_a", valid_in, 0);
    tick();
    check("sf_blocked_b", valid_in, 0);
    done_op_id  = 8'h03;
    rd_data_out = 8'h3C;
    tick();
    done_op_id  = 8'h00;
    rd_data_out = 8'h00;
    check("sf_cpl_valid", cpl_valid, 1);
    check("sf_cpl_id", cpl_id, 3);
    check("sf_cpl_rd", cpl_wr_rd_op, 0);
    check("sf_cpl_data", cpl_rd_data, 8'h3C);
    check("sf_no_reuse_same_edge", valid_in, 0);
    tick();
    check("sf_fifth_valid", valid_in, 1);
    check("sf_fifth_id", op_in_id, 5);
    check("sf_fifth_addr", addr_in, 8'h34);
    tick();

    // Out-of-order and unmatched completions (outstanding 1,2,4,5)
    done_seq[0] = 8'h02;
    done_seq[1] = 8'h04;
    done_seq[2] = 8'h01;
    done_seq[3] = 8'h09;
    done_seq[4] = 8'h00;
    for (int k = 0; k < 5; k++) begin
      done_op_id  = done_seq[k];
      rd_data_out = 8'h40 + done_seq[k];
      tick();
      if (k < 3) begin
        check("ooo_cpl_valid", cpl_valid, 1);
        check("ooo_cpl_id", cpl_id, 32'(done_seq[k]));
        check("ooo_cpl_data", cpl_rd_data, 32'(8'h40 + done_seq[k]));
        check("ooo_err", err_unexpected, 0);
      end else begin
        check("unm_cpl_valid", cpl_valid, 0);
        check("unm_err", err_unexpected, (k == 3) ? 1 : 0);
      end
    end
    done_op_id  = 8'h00;
    rd_data_out = 8'h00;

    // Enable gating
    do_reset();
    ready_out  = 1'b0;
    cfg_enable = 1'b0;
    tick();
    check("en_off", enable_in, 0);
    host_valid    = 1'b1;
    host_wr_rd_op = 1'b1;
    host_addr     = 8'h66;
    host_wr_data  = 8'h99;
    tick();
    host_valid = 1'b0;
    tick();
    tick();
    check("en_no_load", valid_in, 0);
    cfg_enable = 1'b1;
    tick();
    check("en_on", enable_in, 1);
    check("en_load_delay", valid_in, 0);
    tick();
    check("en_loaded", valid_in, 1);
    check("en_loaded_addr", addr_in, 8'h66);

    // ID wrap
    do_reset();
    ready_out = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      issue_op(1'b1, 8'(n), 8'(n), id);
      if (n >= 250) check("wrap_id", id, (n == 256) ? 1 : 32'(n));
      else if (id == 8'h00) check("wrap_nonzero", id, 32'(n));
    end

    // Reset mid-flight: 2 outstanding, 1 in stage, 2 in FIFO
    do_reset();
    ready_out = 1'b1;
    for (int k = 0; k < 2; k++) begin
      host_valid    = 1'b1;
      host_wr_rd_op = 1'b0;
      host_addr     = 8'h70 + 8'(k);
      tick();
    end
    host_valid = 1'b0;
    tick();
    tick();
    ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      host_valid = 1'b1;
      host_addr  = 8'h80 + 8'(k);
      tick();
    end
    host_valid = 1'b0;
    check("mid_stage_id", op_in_id, 3);
    done_op_id = 8'h01;
    reset      = 1'b1;
    tick();
    check("mid_rst_valid_in", valid_in, 0);
    check("mid_rst_op_id", op_in_id, 0);
    check("mid_rst_host_ready", host_ready, 1);
    check("mid_rst_cpl", cpl_valid, 0);
    check("mid_rst_err", err_unexpected, 0);
    reset      = 1'b0;
    done_op_id = 8'h00;
    tick();
    check("mid_post_cpl", cpl_valid, 0);
    check("mid_post_valid", valid_in, 0);
    done_op_id = 8'h02;
    tick();
    done_op_id = 8'h00;
    check("mid_dropped_err", err_unexpected, 1);
    check("mid_dropped_cpl", cpl_valid, 0);
    ready_out = 1'b1;
    issue_op(1'b1, 8'h90, 8'h11, id);
    check("mid_next_id", id, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/op_issue_queue.md
# op_issue_queue

Upstream feeder for the unit address decoder. It buffers host read/write requests in a small FIFO and assigns each one a non-zero operation ID. Requests are presented to the decoder's input port under a valid/ready handshake. The block tracks outstanding IDs in a scoreboard and converts the decoder's `done_op_id`/`rd_data_out` return into one completion pulse per operation.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2)
- `MAX_OUT`, 4: scoreboard entries (max outstanding ops)
- `ADDR_W`, 8: address width
- `DATA_W`, 8: data width
- `ID_W`, 8: operation ID width

- `clock`  in  1  sole clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `cfg_enable`  in  1  decoder enable request
- `host_valid`  in  1  host request valid
- `host_ready`  out  1  FIFO can accept
- `host_wr_rd_op`  in  1  1 = write, 0 = read
- `host_addr`  in  ADDR_W  target address
- `host_wr_data`  in  DATA_W  write data
- `enable_in`  out  1  to decoder; registered `cfg_enable`
- `valid_in`  out  1  to decoder; request valid
- `wr_rd_op`  out  1  to decoder
- `addr_in`  out  ADDR_W  to decoder
- `op_in_id`  out  ID_W  to decoder
- `wr_data_in`  out  DATA_W  to decoder
- `ready_out`  in  1  decoder accepts
- `rd_data_out`  in  DATA_W  decoder read return
- `done_op_id`  in  ID_W  completing ID; 0 = none
- `cpl_valid`  out  1  one-cycle completion pulse
- `cpl_id`  out  ID_W  completed ID
- `cpl_wr_rd_op`  out  1  type of completed op
- `cpl_rd_data`  out  DATA_W  read data; 0 for writes
- `err_unexpected`  out  1  pulse: `done_op_id` ≠0 and matches no scoreboard entry

## Operation
- **Reset values.** All outputs are 0 except `host_ready`, which is 1. The ID counter resets to 1. FIFO and scoreboard are emptied.
- **Host push.** A push occurs at an edge where `host_valid && host_ready`. `host_ready = !fifo_full`.
- **Output stage.** This is a single register set driving the decoder port. It loads the FIFO head when empty, or when it is accepted in the same edge, provided a scoreboard slot is free.
- **ID assignment.** The ID is assigned at load from the counter. The counter increments on each load and wraps from 2^ID_W−1 to 1, never producing 0.
- **Decoder handshake.** Acceptance occurs at an edge where `valid_in && ready_out`. While `valid_in=1` and not accepted, all payload signals and `op_in_id` hold stable.
- **Scoreboard allocation.** On acceptance, the ID and `wr_rd_op` are written into a free scoreboard slot. The lowest free index wins.
- **Scoreboard full.** The output stage does not load and `valid_in` stays 0. The FIFO keeps accepting until it is full.
- **Completion.** At an edge where `done_op_id` matches a valid slot: the slot is freed, `cpl_valid` pulses next cycle, and `cpl_id` = `done_op_id`. `cpl_rd_data` = the `rd_data_out` sampled at that edge if the op was a read, otherwise 0. Completions may arrive in any order.
- **Unmatched completion.** A non-zero `done_op_id` that matches no valid slot produces an `err_unexpected` pulse next cycle and no `cpl_valid`.
- **Enable.** `enable_in` follows `cfg_enable` with a 1-cycle delay. When `enable_in=0`, no load occurs. An already valid request stays valid and may still be accepted.

## Timing
- **Host push to decoder.** A push at edge N into an empty FIFO with an idle stage gives `valid_in=1` after edge N+1. Minimum latency is 1 cycle.
- **Throughput.** Back-to-back: with `ready_out` held high and the scoreboard not full, one request is accepted per cycle.
- **Completion latency.** From `done_op_id` to `cpl_valid` is 1 cycle.
- **Simultaneous events:**
  - **Push and pop.** Push and pop in the same edge leaves occupancy unchanged. A push into a full FIFO is impossible (`host_ready=0`).
  - **Free and allocate.** A completion frees a slot at edge N and an acceptance at edge N allocates a slot. The freed slot is not reusable at N; it is available from N+1.
  - **Same-edge match.** `done_op_id` never matches an entry being allocated at the same edge.
- **Reset mid-operation.** Asserting `reset` at any edge clears all state at that edge. Pending and outstanding ops are dropped silently. No `cpl_valid` or `err_unexpected` follows.

## Structure
- **Shared package (with the existing item types):**
  - `op_req_t` struct: `wr_rd_op`, `addr`, `wr_data`
  - `sb_entry_t` struct: `valid`, `id`, `wr_rd_op`
  - constant `OP_ID_NONE = 0`
- **Sub-module.** One sub-module, `op_req_fifo`: a synchronous FIFO of `op_req_t` with push/pop/full/empty. It is instantiated once. The scoreboard and output stage stay in the top.

## Test plan
- **Single write.** After reset, push write addr 0x10, data 0xA5, with `ready_out=1`. Expect `valid_in` high 1 cycle later with `op_in_id=1`. Then `done_op_id=1` gives `cpl_valid`, `cpl_id=1`, `cpl_wr_rd_op=1`, `cpl_rd_data=0`.
- **Backpressure.** Hold `ready_out=0` and push 5 requests. Expect `host_ready` low after 4 FIFO + 1 stage. `valid_in` payload stays constant. Release: IDs 1–5 are issued in order, one per cycle.
- **Scoreboard full.** Issue 4 reads with no completions. The 5th does not assert `valid_in`. `done_op_id=3` with `rd_data_out=0x3C` gives a completion with data 0x3C. The 5th then issues with ID 5, no earlier than 1 cycle later.
- **Out-of-order and unmatched.** Complete IDs 2, 4, 1 → three `cpl_valid` pulses in that order. `done_op_id=9` → `err_unexpected` pulse and no `cpl_valid`.
- **ID wrap.** Preload the counter to 255 by issuing 254 ops. The next IDs are 255 then 1, never 0.
- **Reset mid-flight.** With 2 ops outstanding and 3 queued, assert `reset` for 1 cycle. All outputs reset and no completion fires. The next op gets ID 1.
